// File: rtl/apb4_mem_slave.sv
// APB4 completer fronting a word-organised RAM with byte strobes, programmable
// wait states and error responses for misaligned, out-of-range and secure accesses.
module apb4_mem_slave #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned SECURE_BASE = DEPTH
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [2:0]              pprot,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned OFF_W = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  state_e                  state_q,   state_d;
  logic [3:0]              cnt_q,     cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
  logic                    write_q,   write_d;
  logic [DATA_WIDTH-1:0]   wdata_q,   wdata_d;
  logic [BYTES-1:0]        strb_q,    strb_d;
  logic                    prot_ns_q, prot_ns_d;
  logic [DATA_WIDTH-1:0]   prdata_q,  prdata_d;
  logic                    pready_q,  pready_d;
  logic                    pslverr_q, pslverr_d;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic                    mem_we;

  logic [ADDR_WIDTH-1:0]   word_idx;
  logic [IDX_W-1:0]        mem_idx;
  logic                    misaligned;
  logic                    out_of_range;
  logic                    secure_err;
  logic                    access_err;

  // Only the non-secure attribute participates in decode.
  logic unused_prot;
  assign unused_prot = ^{pprot[2], pprot[0]};

  // Decode works on the latched request so bus changes during ACCESS are inert.
  always_comb begin
    word_idx     = addr_q >> OFF_W;
    mem_idx      = word_idx[IDX_W-1:0];
    misaligned   = |(addr_q & OFF_MASK);
    out_of_range = 32'(word_idx) >= 32'(DEPTH);
    secure_err   = (32'(word_idx) >= 32'(SECURE_BASE)) && prot_ns_q;
    access_err   = misaligned || out_of_range || secure_err;
  end

  always_comb begin
    // NOTE: every _d starts from its _q so no path through the case leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    prot_ns_d = prot_ns_q;
    prdata_d  = prdata_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    mem_we    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          addr_d    = paddr;
          write_d   = pwrite;
          wdata_d   = pwdata;
          strb_d    = pstrb;
          prot_ns_d = pprot[1];
          cnt_d     = 4'(WAIT_STATES);
          state_d   = ACCESS;
        end
      end

      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (penable) begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            pready_d  = 1'b1;
            pslverr_d = access_err;
            state_d   = DONE;
            if (write_q) begin
              mem_we = !access_err;
            end else begin
              prdata_d = access_err ? '0 : mem_q[mem_idx];
            end
          end
        end
      end

      DONE: begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      prot_ns_q <= 1'b0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      prot_ns_q <= prot_ns_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  // NOTE: the array has no reset branch so it maps onto RAM; contents survive
  // preset, and only a pending write is discarded by gating the enable.
  always_ff @(posedge pclk) begin
    if (mem_we && !preset) begin
      for (int b = 0; b < int'(BYTES); b++) begin
        if (strb_q[b]) begin
          mem_q[mem_idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
        end
      end
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Directed bench: dut_a (2 wait states, secure region at word 128) and
// dut_b (zero wait states) share the request bus; use_b selects the observed one.
module tb_apb4_mem_slave;

  logic        pclk = 1'b0;
  logic        preset, psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata_a, prdata_b;
  logic        pready_a, pready_b, pslverr_a, pslverr_b;
  logic        use_b;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 pclk = ~pclk;

  apb4_mem_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(256),
                   .WAIT_STATES(2), .SECURE_BASE(128)) dut_a (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pprot(pprot), .prdata(prdata_a), .pready(pready_a), .pslverr(pslverr_a)
  );

  apb4_mem_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(256),
                   .WAIT_STATES(0)) dut_b (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pprot(pprot), .prdata(prdata_b), .pready(pready_b), .pslverr(pslverr_b)
  );

  function automatic logic obs_ready();
    return use_b ? pready_b : pready_a;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One transfer starting at the next edge; returns in the pready cycle with
  // psel still high so another call runs back-to-back.
  task automatic xfer(input logic wr, input logic [11:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [2:0] prot,
                      output logic [31:0] rd, output logic err, output int lat);
    @(posedge pclk); #1;
    check("ready_low_at_setup", obs_ready(), 1'b0);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
    pwdata = data; pstrb = strb; pprot = prot;
    @(posedge pclk); #1;
    penable = 1'b1;
    // Disturb the bus during ACCESS; the latched request must be used.
    paddr = addr ^ 12'h004; pwdata = ~data; pstrb = ~strb;
    lat = 0;
    while (!obs_ready() && lat < 40) begin
      @(posedge pclk); #1;
      lat++;
    end
    if (lat >= 40) check("xfer_timeout", 1'b1, 1'b0);
    rd  = use_b ? prdata_b : prdata_a;
    err = use_b ? pslverr_b : pslverr_a;
  endtask

  task automatic idle();
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  logic [31:0] rd, wdat;
  logic        err, seen;
  int          lat;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    use_b = 1'b0;
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
    repeat (3) @(posedge pclk);
    #1;
    check("rst_pready_a", pready_a, 1'b0);
    check("rst_pslverr_a", pslverr_a, 1'b0);
    check("rst_prdata_a", prdata_a, 32'h0);
    check("rst_pready_b", pready_b, 1'b0);
    check("rst_prdata_b", prdata_b, 32'h0);
    preset = 1'b0;

    // Basic write / read with 2 wait states: pready after edge E0+3.
    xfer(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 3'b000, rd, err, lat);
    check("wr_basic_err", err, 1'b0);
    check("wr_basic_lat", lat, 3);
    idle();
    xfer(1'b0, 12'h010, 32'h0, 4'h0, 3'b000, rd, err, lat);
    check("rd_basic_data", rd, 32'hDEADBEEF);
    check("rd_basic_err", err, 1'b0);
    check("rd_basic_lat", lat, 3);
    idle();

    // Partial strobes: lanes 0 and 2 only.
    xfer(1'b1, 12'h010, 32'h11223344, 4'b0101, 3'b000, rd, err, lat);
    idle();
    xfer(1'b0, 12'h010, 32'h0, 4'h0, 3'b000, rd, err, lat);
    check("rd_strb_data", rd, 32'hDE22BE44);
    idle();

    // Out of range write must not disturb prdata.
    xfer(1'b1, 12'h400, 32'hFFFFFFFF, 4'hF, 3'b000, rd, err, lat);
    check("wr_oor_err", err, 1'b1);
    check("wr_oor_prdata_hold", rd, 32'hDE22BE44);
    idle();
    xfer(1'b0, 12'h400, 32'h0, 4'h0, 3'b000, rd, err, lat);
    check("rd_oor_err", err, 1'b1);
    check("rd_oor_data", rd, 32'h0);
    idle();
    xfer(1'b0, 12'h012, 32'h0, 4'h0, 3'b000, rd, err, lat);
    check("rd_misal_err", err, 1'b1);
    check("rd_misal_data", rd, 32'h0);
    idle();
    xfer(1'b1, 12'h3FC, 32'h0BADCAFE, 4'hF, 3'b000, rd, err, lat);
    check("wr_last_err", err, 1'b0);
    idle();
    xfer(1'b0, 12'h3FC, 32'h0, 4'h0, 3'b000, rd, err, lat);
    check("rd_last_err", err, 1'b0);
    check("rd_last_data", rd, 32'h0BADCAFE);
    idle();

    // Zero strobes: OKAY, no change.
    xfer(1'b1, 12'h010, 32'hFFFFFFFF, 4'h0, 3'b000, rd, err, lat);
    check("wr_nostrb_err", err, 1'b0);
    idle();
    xfer(1'b0, 12'h010, 32'h0, 4'h0, 3'b000, rd, err, lat);
    check("rd_nostrb_data", rd, 32'hDE22BE44);
    idle();

    // Secure region from word 128 (0x200).
    xfer(1'b1, 12'h1FC, 32'h01234567, 4'hF, 3'b010, rd, err, lat);
    check("wr_ns_below_secure_err", err, 1'b0);
    idle();
    xfer(1'b1, 12'h200, 32'h5A5A0000, 4'hF, 3'b000, rd, err, lat);
    check("wr_sec_init_err", err, 1'b0);
    idle();
    xfer(1'b1, 12'h200, 32'hA5A5A5A5, 4'hF, 3'b010, rd, err, lat);
    check("wr_sec_ns_err", err, 1'b1);
    idle();
    xfer(1'b0, 12'h200, 32'h0, 4'h0, 3'b000, rd, err, lat);
    check("rd_sec_unchanged", rd, 32'h5A5A0000);
    idle();
    xfer(1'b1, 12'h200, 32'hA5A5A5A5, 4'hF, 3'b000, rd, err, lat);
    idle();
    xfer(1'b0, 12'h200, 32'h0, 4'h0, 3'b000, rd, err, lat);
    check("rd_sec_data", rd, 32'hA5A5A5A5);
    check("rd_sec_err", err, 1'b0);
    idle();
    xfer(1'b0, 12'h200, 32'h0, 4'h0, 3'b010, rd, err, lat);
    check("rd_sec_ns_err", err, 1'b1);
    check("rd_sec_ns_data", rd, 32'h0);
    idle();

    // Abort: psel dropped during a wait cycle.
    xfer(1'b1, 12'h020, 32'hCAFEF00D, 4'hF, 3'b000, rd, err, lat);
    idle();
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h020;
    pwdata = 32'h12345678; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge pclk); #1;
      seen = seen | pready_a;
    end
    check("abort_no_pready", seen, 1'b0);
    xfer(1'b0, 12'h020, 32'h0, 4'h0, 3'b000, rd, err, lat);
    check("abort_mem_unchanged", rd, 32'hCAFEF00D);
    idle();

    // Reset on the edge where the write would execute.
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h020;
    pwdata = 32'h12345678; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    preset = 1'b1;
    @(posedge pclk); #1;
    check("midrst_pready", pready_a, 1'b0);
    check("midrst_pslverr", pslverr_a, 1'b0);
    check("midrst_prdata", prdata_a, 32'h0);
    preset = 1'b0; psel = 1'b0; penable = 1'b0;
    repeat (2) @(posedge pclk);
    xfer(1'b0, 12'h020, 32'h0, 4'h0, 3'b000, rd, err, lat);
    check("midrst_mem_unchanged", rd, 32'hCAFEF00D);
    idle();

    // Back-to-back alternating write/read on the zero-wait instance.
    use_b = 1'b1;
    idle();
    for (int i = 0; i < 16; i++) begin
      wdat = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
      xfer(1'b1, 12'(i * 4), wdat, 4'hF, 3'b000, rd, err, lat);
      check("b2b_wr_lat", lat, 1);
      check("b2b_wr_err", err, 1'b0);
      xfer(1'b0, 12'(i * 4), 32'h0, 4'h0, 3'b000, rd, err, lat);
      check("b2b_rd_lat", lat, 1);
      check("b2b_rd_data", rd, wdat);
    end
    @(posedge pclk); #1;
    check("b2b_ready_single", pready_b, 1'b0);
    psel = 1'b0; penable = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
